// File: rtl/floo_vc_rx_buffer.sv
`default_nettype none
// ============================================================================
// Package     : floo_pkg (minimal subset)
// Description : Virtual-channel implementation selector shared by the link
//               transmit and receive ends.
// Revision    : 1.0 - initial release
// ============================================================================
package floo_pkg;
    typedef enum logic [1:0] {
        VcNaive        = 2'd0,
        VcCreditBased  = 2'd1,
        VcPreemptValid = 2'd2
    } vc_impl_e;
endpackage

// ============================================================================
// Module      : floo_vc_rx_buffer
// Description : Receive end of a virtually-channelled link. Each incoming
//               flit is steered by its one-hot valid into a per-VC circular
//               FIFO whose head is presented to the downstream port. In
//               credit-based mode every dequeue returns a one-cycle credit
//               pulse upstream; in the other modes per-VC fullness is shown
//               as ready.
// Ports       : clk_i      - clock
//               rst_ni     - synchronous active-low reset
//               valid_i    - link valid, one-hot0, bit v = flit for VC v
//               ready_o    - per-VC ready to the link (FIFO not full)
//               data_i     - link flit, shared by all VCs
//               valid_o    - per-VC FIFO head valid
//               ready_i    - per-VC downstream ready
//               data_o     - per-VC FIFO head data
//               credit_o   - per-VC credit return pulse (credit mode only)
//               overflow_o - sticky: flit arrived on a full VC (credit mode)
// Revision    : 1.0 - initial release
// ============================================================================
module floo_vc_rx_buffer #(
    parameter int unsigned        NUM_VIRT_CHANNELS  = 2,
    parameter type                flit_t             = logic,
    parameter floo_pkg::vc_impl_e VC_IMPL            = floo_pkg::VcNaive,
    parameter int unsigned        NUM_CREDITS        = 3,
    // Lets a harness deliberately provoke the credit-mode overflow path.
    parameter bit                 ASSERT_NO_OVERFLOW = 1'b1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic  [NUM_VIRT_CHANNELS-1:0]       valid_i,
    output logic  [NUM_VIRT_CHANNELS-1:0]       ready_o,
    input  flit_t                               data_i,
    output logic  [NUM_VIRT_CHANNELS-1:0]       valid_o,
    input  logic  [NUM_VIRT_CHANNELS-1:0]       ready_i,
    output flit_t [NUM_VIRT_CHANNELS-1:0]       data_o,
    output logic  [NUM_VIRT_CHANNELS-1:0]       credit_o,
    output logic                                overflow_o
);

    localparam int unsigned        c_PTR_W        = (NUM_CREDITS > 1) ? $clog2(NUM_CREDITS) : 1;
    localparam int unsigned        c_CNT_W        = $clog2(NUM_CREDITS + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST     = c_PTR_W'(NUM_CREDITS - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL     = c_CNT_W'(NUM_CREDITS);
    localparam bit                 c_CREDIT_BASED = (VC_IMPL == floo_pkg::VcCreditBased);

    // Explicit wrap so that non-power-of-two depths work.
    function automatic logic [c_PTR_W-1:0] f_ptr_inc(input logic [c_PTR_W-1:0] ptr);
        return (ptr == c_PTR_LAST) ? '0 : ptr + c_PTR_W'(1);
    endfunction

    logic [NUM_VIRT_CHANNELS-1:0] w_ovf;
    logic                         r_overflow;

    for (genvar v = 0; v < NUM_VIRT_CHANNELS; v++) begin : g_vc
        flit_t              r_mem [NUM_CREDITS];
        logic [c_PTR_W-1:0] r_wr_ptr;
        logic [c_PTR_W-1:0] r_rd_ptr;
        logic [c_CNT_W-1:0] r_count;
        logic               w_push;
        logic               w_pop;

        // Ready depends only on stored state: a pop in the same cycle does
        // not free a slot early, keeping ready_i off the ready_o path.
        assign ready_o[v] = (r_count != c_CNT_FULL);
        assign valid_o[v] = (r_count != '0);
        assign data_o[v]  = r_mem[r_rd_ptr];

        assign w_push   = valid_i[v] & ready_o[v];
        assign w_pop    = valid_o[v] & ready_i[v];
        assign w_ovf[v] = c_CREDIT_BASED & valid_i[v] & ~ready_o[v];

        // Storage is not reset; the count alone defines which slots are live.
        always_ff @(posedge clk_i) begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= data_i;
            end
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= f_ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= f_ptr_inc(r_rd_ptr);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + c_CNT_W'(1);
                    2'b01:   r_count <= r_count - c_CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end

        if (c_CREDIT_BASED) begin : g_credit
            logic r_credit;

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    r_credit <= 1'b0;
                end else begin
                    r_credit <= w_pop;
                end
            end

            assign credit_o[v] = r_credit;
        end else begin : g_no_credit
            assign credit_o[v] = 1'b0;
        end

        // Head must hold while the downstream stalls.
        assert property (@(posedge clk_i) disable iff (!rst_ni)
            (valid_o[v] && !ready_i[v]) |=> $stable(data_o[v]));

        if (c_CREDIT_BASED && ASSERT_NO_OVERFLOW) begin : g_ovf_chk
            assert property (@(posedge clk_i) disable iff (!rst_ni)
                !(valid_i[v] && !ready_o[v]));
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_overflow <= 1'b0;
        end else if (|w_ovf) begin
            r_overflow <= 1'b1;
        end
    end

    assign overflow_o = r_overflow;

    assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(valid_i));
    assert property (@(posedge clk_i) NUM_CREDITS >= 1);

endmodule
`default_nettype wire

// File: tb/tb_floo_vc_rx_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_floo_vc_rx_buffer
// Description : Self-checking bench for floo_vc_rx_buffer. A credit-based and
//               a naive instance share the same stimulus; a list-based model
//               of each VC predicts every output on every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_floo_vc_rx_buffer;

    localparam int DEPTH = 3;
    typedef logic [7:0] flit_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_ni;
    logic [1:0]  valid_i;
    logic [1:0]  ready_i;
    flit_t       data_i;

    logic [1:0]  cb_ready_o, cb_valid_o, cb_credit_o;
    flit_t [1:0] cb_data_o;
    logic        cb_overflow_o;
    logic [1:0]  nv_ready_o, nv_valid_o, nv_credit_o;
    flit_t [1:0] nv_data_o;
    logic        nv_overflow_o;

    floo_vc_rx_buffer #(
        .NUM_VIRT_CHANNELS (2),
        .flit_t            (flit_t),
        .VC_IMPL           (floo_pkg::VcCreditBased),
        .NUM_CREDITS       (DEPTH),
        .ASSERT_NO_OVERFLOW(1'b0)
    ) dut_cb (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (cb_ready_o),
        .data_i    (data_i),
        .valid_o   (cb_valid_o),
        .ready_i   (ready_i),
        .data_o    (cb_data_o),
        .credit_o  (cb_credit_o),
        .overflow_o(cb_overflow_o)
    );

    floo_vc_rx_buffer #(
        .NUM_VIRT_CHANNELS (2),
        .flit_t            (flit_t),
        .VC_IMPL           (floo_pkg::VcNaive),
        .NUM_CREDITS       (DEPTH),
        .ASSERT_NO_OVERFLOW(1'b1)
    ) dut_nv (
        .clk_i     (clk),
        .rst_ni    (rst_ni),
        .valid_i   (valid_i),
        .ready_o   (nv_ready_o),
        .data_i    (data_i),
        .valid_o   (nv_valid_o),
        .ready_i   (ready_i),
        .data_o    (nv_data_o),
        .credit_o  (nv_credit_o),
        .overflow_o(nv_overflow_o)
    );

    int total = 0;
    int bad   = 0;

    // Model: each VC is an ordered list, index 0 is the oldest flit.
    flit_t      mq [2][DEPTH];
    int         mcnt [2]      = '{0, 0};
    logic [1:0] exp_credit    = 2'b00;
    logic       exp_ovf       = 1'b0;
    logic [1:0] m_pushed      = 2'b00;
    int         cb_credits [2] = '{0, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_ready();
        logic [1:0] r;
        for (int v = 0; v < 2; v++) r[v] = (mcnt[v] != DEPTH);
        return r;
    endfunction

    function automatic logic [1:0] m_valid();
        logic [1:0] r;
        for (int v = 0; v < 2; v++) r[v] = (mcnt[v] != 0);
        return r;
    endfunction

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic step();
        logic full, push, pop;
        @(posedge clk);
        if (!rst_ni) begin
            mcnt       = '{0, 0};
            exp_credit = 2'b00;
            exp_ovf    = 1'b0;
            m_pushed   = 2'b00;
        end else begin
            for (int v = 0; v < 2; v++) begin
                full = (mcnt[v] == DEPTH);
                push = valid_i[v] && !full;
                pop  = (mcnt[v] > 0) && ready_i[v];
                if (valid_i[v] && full) exp_ovf = 1'b1;
                if (pop) begin
                    for (int i = 0; i < DEPTH - 1; i++) mq[v][i] = mq[v][i+1];
                    mcnt[v]--;
                end
                if (push) begin
                    mq[v][mcnt[v]] = data_i;
                    mcnt[v]++;
                end
                exp_credit[v] = pop;
                m_pushed[v]   = push;
            end
        end
        #1;
        chk("cb.ready",    cb_ready_o,    m_ready());
        chk("cb.valid",    cb_valid_o,    m_valid());
        chk("cb.credit",   cb_credit_o,   exp_credit);
        chk("cb.overflow", cb_overflow_o, exp_ovf);
        chk("nv.ready",    nv_ready_o,    m_ready());
        chk("nv.valid",    nv_valid_o,    m_valid());
        chk("nv.credit",   nv_credit_o,   2'b00);
        chk("nv.overflow", nv_overflow_o, 1'b0);
        for (int v = 0; v < 2; v++) begin
            if (mcnt[v] != 0) begin
                chk($sformatf("cb.data%0d", v), cb_data_o[v], mq[v][0]);
                chk($sformatf("nv.data%0d", v), nv_data_o[v], mq[v][0]);
            end
            cb_credits[v] += int'(cb_credit_o[v]);
        end
    endtask

    initial begin
        rst_ni  = 1'b0;
        valid_i = 2'b00;
        ready_i = 2'b00;
        data_i  = '0;
        step();
        step();
        rst_ni = 1'b1;
        chk("lit.rst_ready_cb", cb_ready_o, 2'b11);
        chk("lit.rst_ready_nv", nv_ready_o, 2'b11);
        chk("lit.rst_valid",    cb_valid_o, 2'b00);
        chk("lit.rst_ovf",      cb_overflow_o, 1'b0);

        // Basic steering
        ready_i = 2'b11;
        valid_i = 2'b01; data_i = 8'hA1;
        step();
        chk("lit.a_valid", cb_valid_o[0], 1'b1);
        chk("lit.a_data",  cb_data_o[0],  8'hA1);
        valid_i = 2'b10; data_i = 8'hB2;
        step();
        chk("lit.a_credit", cb_credit_o,  2'b01);
        chk("lit.b_data",   cb_data_o[1], 8'hB2);
        valid_i = 2'b00;
        step();
        chk("lit.b_credit", cb_credit_o, 2'b10);
        step();

        // Fill VC0 with its consumer stalled, then drain
        cb_credits[0] = 0;
        ready_i = 2'b10;
        for (int i = 0; i < 3; i++) begin
            valid_i = 2'b01; data_i = flit_t'(8'hC0 + i);
            step();
        end
        chk("lit.full_ready", cb_ready_o, 2'b10);
        valid_i = 2'b00; ready_i = 2'b11;
        for (int i = 0; i < 5; i++) step();
        chk("lit.fill_credits", cb_credits[0], 3);

        // Continuous push+pop on VC1 across pointer wrap
        cb_credits[1] = 0;
        for (int i = 0; i < 10; i++) begin
            valid_i = 2'b10; data_i = flit_t'(8'h50 + i);
            step();
        end
        valid_i = 2'b00;
        for (int i = 0; i < 3; i++) step();
        chk("lit.wrap_credits", cb_credits[1], 10);

        // Overflow on a full VC0
        ready_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            valid_i = 2'b01; data_i = flit_t'(8'hE0 + i);
            step();
        end
        valid_i = 2'b01; data_i = 8'hDD;
        step();
        step();
        chk("lit.ovf_cb",   cb_overflow_o, 1'b1);
        chk("lit.ovf_nv",   nv_overflow_o, 1'b0);
        chk("lit.ovf_head", cb_data_o[0],  8'hE0);
        ready_i = 2'b01;
        for (int k = 0; k < 6; k++) begin
            step();
            if (m_pushed[0]) break;
        end
        valid_i = 2'b00; ready_i = 2'b11;
        for (int i = 0; i < 5; i++) step();
        chk("lit.ovf_sticky", cb_overflow_o, 1'b1);

        // Reset with flits stored
        ready_i = 2'b00;
        for (int i = 0; i < 2; i++) begin
            valid_i = 2'b01; data_i = flit_t'(8'hF0 + i);
            step();
        end
        valid_i = 2'b00;
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        chk("lit.mid_valid",  cb_valid_o,    2'b00);
        chk("lit.mid_ready",  cb_ready_o,    2'b11);
        chk("lit.mid_credit", cb_credit_o,   2'b00);
        chk("lit.mid_ovf",    cb_overflow_o, 1'b0);
        ready_i = 2'b11;
        for (int i = 0; i < 3; i++) step();

        // Randomised traffic with occasional resets
        for (int n = 0; n < 600; n++) begin
            case ($urandom_range(0, 3))
                1:       valid_i = 2'b01;
                2:       valid_i = 2'b10;
                default: valid_i = 2'b00;
            endcase
            data_i  = flit_t'($urandom);
            ready_i = 2'($urandom);
            rst_ni  = ($urandom_range(0, 99) != 0);
            step();
        end
        rst_ni  = 1'b1;
        valid_i = 2'b00;
        ready_i = 2'b11;
        for (int i = 0; i < 4; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
